// File: rtl/diff_core_pkg.sv
// Shared types for the differential PE core: weight modes, sequencer state and
// the step-index width helper used by the column sequencer.
package diff_core_pkg;

  typedef enum logic [2:0] {
    A_MODE = 3'd0,
    B_MODE = 3'd1,
    C_MODE = 3'd2,
    D_MODE = 3'd3,
    E_MODE = 3'd4
  } PE_weight_mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

  localparam int GUARD_W_DEF = 6;

  // Step 0 means "no tap", so the index must reach GUARD_W inclusive.
  function automatic int step_idx_w(input int guard_w);
    return $clog2(guard_w + 1);
  endfunction

endpackage

// File: rtl/guard_prio_enc.sv
// Priority encoder over the remaining guard bits: reports the tap number of the
// highest set bit, a one-hot mask to clear it, and whether it is the last one.
module guard_prio_enc
  import diff_core_pkg::*;
#(
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int IDX_W   = step_idx_w(GUARD_W)
) (
  input  logic [GUARD_W-1:0] rem,
  output logic [IDX_W-1:0]   idx,
  output logic [GUARD_W-1:0] clr_mask,
  output logic               any,
  output logic               last
);

  // Ascending scan so the highest set bit (lowest tap number) wins.
  always_comb begin
    idx      = '0;
    clr_mask = '0;
    for (int i = 0; i < GUARD_W; i++) begin
      if (rem[i]) begin
        idx         = IDX_W'(GUARD_W - i);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
    any  = |rem;
    last = any && ((rem & (rem - GUARD_W'(1))) == '0);
  end

endmodule

// File: rtl/pe_col_seq_ctrl.sv
// Column sequencer: accepts guard maps over valid/ready and issues one tap per
// unstalled cycle, MSB-first, with back-to-back maps and no bubbles.
module pe_col_seq_ctrl
  import diff_core_pkg::*;
#(
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int IDX_W   = step_idx_w(GUARD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [GUARD_W-1:0]   guard_map_i,
  input  logic                 bit_mode_i,
  input  logic                 kernal_mode_i,
  input  logic                 is_odd_row_i,
  input  logic                 end_of_row_i,
  input  logic                 stall_i,
  output logic [IDX_W-1:0]     step_o,
  output logic                 step_valid_o,
  output PE_weight_mode_t      weight_mode_o,
  output logic                 end_of_row_o,
  output logic                 finish_o,
  output logic                 activation_en_o
);

  seq_state_t         state_q, state_d;
  logic [GUARD_W-1:0] rem_q, rem_d;
  logic               odd_q, odd_d;
  logic               kmode_q, kmode_d;
  logic               eor_q, eor_d;

  logic [IDX_W-1:0]   idx;
  logic [GUARD_W-1:0] clr_mask;
  logic               any;
  logic               last;
  logic               run;
  logic               issuing_last;
  logic               accept;

  guard_prio_enc #(
    .GUARD_W (GUARD_W),
    .IDX_W   (IDX_W)
  ) u_prio (
    .rem      (rem_q),
    .idx      (idx),
    .clr_mask (clr_mask),
    .any      (any),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      odd_q   <= 1'b0;
      kmode_q <= 1'b0;
      eor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      odd_q   <= odd_d;
      kmode_q <= kmode_d;
      eor_q   <= eor_d;
    end
  end

  // An empty map in RUN counts as "last" so its finish pulse lands one cycle after accept.
  always_comb begin
    run          = (state_q == S_RUN);
    issuing_last = run && (last || !any);
    ready_o      = !stall_i && (!run || issuing_last);
    accept       = valid_i && ready_o;
    step_valid_o = run && any && !stall_i;
    finish_o     = issuing_last && !stall_i;
    step_o       = run ? idx : '0;
    end_of_row_o = eor_q;

    weight_mode_o = A_MODE;
    if (run && any) begin
      if (!kmode_q)    weight_mode_o = E_MODE;
      else if (idx[0]) weight_mode_o = odd_q ? A_MODE : B_MODE;
      else             weight_mode_o = odd_q ? C_MODE : D_MODE;
    end

    activation_en_o = step_valid_o || accept;

    state_d = state_q;
    rem_d   = rem_q;
    odd_d   = odd_q;
    kmode_d = kmode_q;
    eor_d   = eor_q;
    if (accept) begin
      state_d = S_RUN;
      rem_d   = bit_mode_i ? '1 : guard_map_i;
      odd_d   = is_odd_row_i;
      kmode_d = kernal_mode_i;
      eor_d   = end_of_row_i;
    end else if (!stall_i && run) begin
      if (issuing_last) begin
        state_d = S_IDLE;
        rem_d   = '0;
      end else begin
        rem_d = rem_q & ~clr_mask;
      end
    end
  end

endmodule

// File: tb/tb_pe_col_seq_ctrl.sv
// Self-checking bench for pe_col_seq_ctrl: directed scenarios then random traffic,
// all compared against a tap-queue reference model.
module tb_pe_col_seq_ctrl;
  import diff_core_pkg::*;

  localparam int GW = 6;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [GW-1:0] guard_map_i;
  logic          bit_mode_i;
  logic          kernal_mode_i;
  logic          is_odd_row_i;
  logic          end_of_row_i;
  logic          stall_i;
  logic [IW-1:0] step_o;
  logic          step_valid_o;
  PE_weight_mode_t weight_mode_o;
  logic          end_of_row_o;
  logic          finish_o;
  logic          activation_en_o;

  int checks = 0;
  int errors = 0;

  // Reference model: taps still to issue for the active map, in issue order.
  int taps[$];
  bit busy  = 0;
  bit m_odd = 0;
  bit m_km  = 0;
  bit m_eor = 0;

  int seenSteps[$];
  int finCount = 0;

  pe_col_seq_ctrl #(.GUARD_W(GW)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .guard_map_i     (guard_map_i),
    .bit_mode_i      (bit_mode_i),
    .kernal_mode_i   (kernal_mode_i),
    .is_odd_row_i    (is_odd_row_i),
    .end_of_row_i    (end_of_row_i),
    .stall_i         (stall_i),
    .step_o          (step_o),
    .step_valid_o    (step_valid_o),
    .weight_mode_o   (weight_mode_o),
    .end_of_row_o    (end_of_row_o),
    .finish_o        (finish_o),
    .activation_en_o (activation_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic PE_weight_mode_t expMode(input int k);
    if (!m_km)      return E_MODE;
    if (k % 2 == 1) return m_odd ? A_MODE : B_MODE;
    return m_odd ? C_MODE : D_MODE;
  endfunction

  function automatic bit expLast();
    return busy && (taps.size() <= 1);
  endfunction

  function automatic bit expReady();
    return !stall_i && (!busy || expLast());
  endfunction

  task automatic checkOutput();
    int  head;
    bit  eSv;
    head = (taps.size() > 0) ? taps[0] : 0;
    eSv  = busy && (taps.size() > 0) && !stall_i;
    chk("ready", ready_o, expReady());
    chk("step", step_o, busy ? head : 0);
    chk("step_valid", step_valid_o, eSv);
    chk("finish", finish_o, expLast() && !stall_i);
    chk("act_en", activation_en_o, eSv || (valid_i && expReady()));
    chk("eor", end_of_row_o, m_eor);
    if (busy && taps.size() > 0) chk("wmode", weight_mode_o, expMode(head));
    if (step_valid_o === 1'b1) seenSteps.push_back(int'(step_o));
    if (finish_o === 1'b1) finCount++;
  endtask

  task automatic modelUpdate();
    logic [GW-1:0] eff;
    if (rst) begin
      busy = 0; taps.delete(); m_odd = 0; m_km = 0; m_eor = 0;
    end else if (!stall_i) begin
      if (valid_i && expReady()) begin
        eff = bit_mode_i ? '1 : guard_map_i;
        taps.delete();
        for (int k = 1; k <= GW; k++) if (eff[GW-k]) taps.push_back(k);
        busy = 1; m_odd = is_odd_row_i; m_km = kernal_mode_i; m_eor = end_of_row_i;
      end else if (busy) begin
        if (taps.size() <= 1) begin
          busy = 0; taps.delete();
        end else begin
          void'(taps.pop_front());
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic applyStimulus(input bit r, input bit v, input logic [GW-1:0] m, input bit bm,
                               input bit km, input bit od, input bit eo, input bit st);
    rst = r; valid_i = v; guard_map_i = m; bit_mode_i = bm;
    kernal_mode_i = km; is_odd_row_i = od; end_of_row_i = eo; stall_i = st;
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int f0;
    rst = 1; valid_i = 0; guard_map_i = '0; bit_mode_i = 0;
    kernal_mode_i = 0; is_odd_row_i = 0; end_of_row_i = 0; stall_i = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_wmode", weight_mode_o, A_MODE);
    chk("reset_ready", ready_o, 1);
    idle(1);

    $display("[TB] scenario 1: sparse map, kernel mode, odd row");
    seenSteps.delete(); f0 = finCount;
    applyStimulus(0, 1, 6'b101001, 0, 1, 1, 1, 0);
    idle(4);
    chk("t1_nsteps", seenSteps.size(), 3);
    if (seenSteps.size() == 3) begin
      chk("t1_s0", seenSteps[0], 1);
      chk("t1_s1", seenSteps[1], 3);
      chk("t1_s2", seenSteps[2], 6);
    end
    chk("t1_fin", finCount - f0, 1);

    $display("[TB] scenario 2: zero map");
    seenSteps.delete(); f0 = finCount;
    applyStimulus(0, 1, 6'b000000, 0, 1, 0, 0, 0);
    idle(2);
    chk("t2_nsteps", seenSteps.size(), 0);
    chk("t2_fin", finCount - f0, 1);

    $display("[TB] scenario 3: back-to-back maps");
    seenSteps.delete(); f0 = finCount;
    applyStimulus(0, 1, 6'b010000, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 6'b000011, 0, 1, 1, 1, 0);
    idle(3);
    chk("t3_nsteps", seenSteps.size(), 3);
    if (seenSteps.size() == 3) begin
      chk("t3_s0", seenSteps[0], 2);
      chk("t3_s1", seenSteps[1], 5);
      chk("t3_s2", seenSteps[2], 6);
    end
    chk("t3_fin", finCount - f0, 2);

    $display("[TB] scenario 4: 4-bit dense mode");
    seenSteps.delete(); f0 = finCount;
    applyStimulus(0, 1, 6'b000000, 1, 0, 1, 0, 0);
    idle(7);
    chk("t4_nsteps", seenSteps.size(), 6);
    chk("t4_fin", finCount - f0, 1);

    $display("[TB] scenario 5: stall mid-walk");
    seenSteps.delete();
    applyStimulus(0, 1, 6'b111111, 0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 6'b000001, 0, 1, 1, 1, 1);
    idle(5);
    chk("t5_nsteps", seenSteps.size(), 6);
    if (seenSteps.size() == 6) chk("t5_s3", seenSteps[3], 4);

    $display("[TB] scenario 6: reset mid-walk");
    seenSteps.delete();
    applyStimulus(0, 1, 6'b111111, 0, 1, 1, 1, 0);
    idle(1);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 1, 6'b100001, 0, 1, 1, 0, 0);
    idle(3);
    chk("t6_nsteps", seenSteps.size(), 4);
    if (seenSteps.size() == 4) chk("t6_s2", seenSteps[2], 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                    GW'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
